// File: rtl/ahb_icache_assoc_pkg.sv
// Shared types, bus encodings and width helpers for the set-associative instruction cache.
package ahb_icache_assoc_pkg;

  // Controller states: lookup, downstream line refill, and the two-cycle error response.
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StWrite,
    StResp,
    StErr1,
    StErr2
  } state_e;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HburstIncr   = 3'b001;
  localparam logic [2:0] HburstIncr4  = 3'b011;
  localparam logic [2:0] HburstIncr8  = 3'b101;
  localparam logic [2:0] HburstIncr16 = 3'b111;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  // Vector width that never collapses to zero for degenerate (single-entry) counts.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Fixed-length burst when the line matches one, otherwise undefined-length INCR.
  function automatic logic [2:0] burst_for_beats(int unsigned beats);
    if (beats == 4) return HburstIncr4;
    else if (beats == 8) return HburstIncr8;
    else if (beats == 16) return HburstIncr16;
    else return HburstIncr;
  endfunction

endpackage

// File: rtl/ahb_icache_assoc_way_array.sv
// One cache way: valid bits, tags and line data per set, combinational lookup,
// synchronous line write. Only the valid bits are reset.
module ahb_icache_assoc_way_array
  import ahb_icache_assoc_pkg::*;
#(
  parameter int unsigned Sets  = 256,
  parameter int unsigned IdxW  = 8,
  parameter int unsigned TagW  = 20,
  parameter int unsigned LineW = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inv_all_i,
  input  logic [IdxW-1:0]  idx_i,
  input  logic [TagW-1:0]  tag_i,
  input  logic             we_i,
  input  logic             wr_valid_i,
  input  logic [LineW-1:0] wr_line_i,
  output logic             hit_o,
  output logic             valid_o,
  output logic [LineW-1:0] line_o
);

  logic [Sets-1:0]  valid_q;
  logic [TagW-1:0]  tag_q  [Sets];
  logic [LineW-1:0] data_q [Sets];

  // Valid bits: flush wins over a same-cycle line write so a flushed refill stays invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= wr_valid_i;
    end
  end

  // Tag and data storage, no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wr_line_i;
    end
  end

  // Combinational read and tag compare for the addressed set.
  always_comb begin
    valid_o = valid_q[idx_i];
    hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    line_o  = data_q[idx_i];
  end

endmodule

// File: rtl/ahb_icache_assoc.sv
// Read-only N-way set-associative AHB-lite instruction cache. Hits answer with zero
// wait states; misses refill a full line with one incrementing burst before answering.
module ahb_icache_assoc
  import ahb_icache_assoc_pkg::*;
#(
  parameter int unsigned CACHE_SIZE = 8192,
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              hclk,
  input  logic              hrstn,
  input  logic [ADDR_W-1:0] s_haddr,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  output logic [DATA_W-1:0] s_hrdata,
  output logic              s_hready,
  output logic              s_hresp,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic [2:0]        m_hburst,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  input  logic [DATA_W-1:0] m_hrdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic              inv_all,
  output logic              stat_hit,
  output logic              stat_miss
);

  localparam int unsigned Sets  = CACHE_SIZE * 8 / CACHE_LINE / WAYS;
  localparam int unsigned OffW  = $clog2(CACHE_LINE / 8);
  localparam int unsigned IdxW  = clog2_min1(Sets);
  localparam int unsigned TagW  = ADDR_W - OffW - $clog2(Sets);
  localparam int unsigned Beats = CACHE_LINE / DATA_W;
  localparam int unsigned ByteW = $clog2(DATA_W / 8);
  localparam int unsigned WselW = clog2_min1(Beats);
  localparam int unsigned CntW  = $clog2(Beats) + 1;
  localparam int unsigned RrW   = clog2_min1(WAYS);

  state_e            state_q, state_d;
  logic              dph_valid_q, dph_write_q;
  logic [ADDR_W-1:0] dph_addr_q;
  logic [CntW-1:0]   addr_cnt_q, addr_cnt_d;
  logic [CntW-1:0]   data_cnt_q, data_cnt_d;
  logic              inv_pend_q, inv_pend_d;
  logic              buf_we;
  logic [DATA_W-1:0] line_buf_q [Beats];
  logic [RrW-1:0]    rr_q [Sets];

  logic [IdxW-1:0]       idx;
  logic [TagW-1:0]       tag;
  logic [WselW-1:0]      word_sel;
  logic [ADDR_W-1:0]     line_base;
  logic [WAYS-1:0]       way_hit, way_valid, way_we;
  logic [CACHE_LINE-1:0] way_line [WAYS];
  logic [CACHE_LINE-1:0] hit_line, wr_line;
  logic [DATA_W-1:0]     hit_words [Beats];
  logic                  hit;
  logic [RrW-1:0]        victim;
  logic                  victim_found;
  logic                  unused_bits;

  assign idx         = dph_addr_q[OffW +: IdxW];
  assign tag         = dph_addr_q[ADDR_W-1 -: TagW];
  assign word_sel    = dph_addr_q[ByteW +: WselW];
  assign line_base   = {dph_addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign hit         = |way_hit;
  assign unused_bits = ^{s_htrans[0], dph_addr_q[ByteW-1:0]};

  assign m_hburst = burst_for_beats(Beats);
  assign m_hwrite = 1'b0;
  assign m_hsize  = 3'(ByteW);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = (state_q == StWrite) && (victim == RrW'(w));

    ahb_icache_assoc_way_array #(
      .Sets  (Sets),
      .IdxW  (IdxW),
      .TagW  (TagW),
      .LineW (CACHE_LINE)
    ) u_way (
      .clk_i      (hclk),
      .rst_ni     (hrstn),
      .inv_all_i  (inv_all),
      .idx_i      (idx),
      .tag_i      (tag),
      .we_i       (way_we[w]),
      .wr_valid_i (!inv_pend_q),
      .wr_line_i  (wr_line),
      .hit_o      (way_hit[w]),
      .valid_o    (way_valid[w]),
      .line_o     (way_line[w])
    );
  end

  // Select the matching way's line and split lines into bus words.
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = way_line[w];
    end
    wr_line = '0;
    for (int b = 0; b < Beats; b++) begin
      hit_words[b]                 = hit_line[b*DATA_W +: DATA_W];
      wr_line[b*DATA_W +: DATA_W]  = line_buf_q[b];
    end
  end

  // Victim: lowest invalid way of the set, otherwise that set's round-robin pointer.
  always_comb begin
    victim       = rr_q[idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !way_valid[w]) begin
        victim       = RrW'(w);
        victim_found = 1'b1;
      end
    end
  end

  // A flush seen while the line is in flight must keep that line from being validated.
  assign inv_pend_d = ((state_q == StReq) || (state_q == StFill)) && (inv_pend_q || inv_all);

  // Next state, upstream response and downstream burst control.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;
    buf_we     = 1'b0;
    s_hready   = 1'b1;
    s_hresp    = HrespOkay;
    s_hrdata   = '0;
    m_htrans   = HtransIdle;
    m_haddr    = '0;
    stat_hit   = 1'b0;
    stat_miss  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dph_valid_q) begin
          if (dph_write_q) begin
            // First error cycle is the data phase itself.
            s_hready = 1'b0;
            s_hresp  = HrespError;
            state_d  = StErr2;
          end else if (hit) begin
            s_hrdata = hit_words[word_sel];
            stat_hit = 1'b1;
          end else begin
            s_hready  = 1'b0;
            stat_miss = 1'b1;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        s_hready = 1'b0;
        m_htrans = HtransNonseq;
        m_haddr  = line_base;
        if (m_hready) begin
          addr_cnt_d = CntW'(1);
          data_cnt_d = '0;
          state_d    = StFill;
        end
      end
      StFill: begin
        s_hready = 1'b0;
        if (m_hresp) begin
          // Abandon the burst: the pending address is withdrawn as IDLE.
          state_d = StErr1;
        end else begin
          if (addr_cnt_q < CntW'(Beats)) begin
            m_htrans = HtransSeq;
            m_haddr  = line_base + (ADDR_W'(addr_cnt_q) << ByteW);
          end
          if (m_hready) begin
            buf_we     = 1'b1;
            data_cnt_d = data_cnt_q + 1'b1;
            if (addr_cnt_q < CntW'(Beats)) addr_cnt_d = addr_cnt_q + 1'b1;
            if (data_cnt_q == CntW'(Beats - 1)) state_d = StWrite;
          end
        end
      end
      StWrite: begin
        s_hready = 1'b0;
        state_d  = StResp;
      end
      StResp: begin
        s_hrdata = line_buf_q[word_sel];
        state_d  = StIdle;
      end
      StErr1: begin
        s_hready = 1'b0;
        s_hresp  = HrespError;
        state_d  = StErr2;
      end
      StErr2: begin
        s_hresp = HrespError;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, address-phase capture, refill counters, line buffer and round-robin pointers.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q     <= StIdle;
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_addr_q  <= '0;
      addr_cnt_q  <= '0;
      data_cnt_q  <= '0;
      inv_pend_q  <= 1'b0;
      for (int b = 0; b < Beats; b++) line_buf_q[b] <= '0;
      for (int s = 0; s < Sets; s++) rr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
      inv_pend_q <= inv_pend_d;
      if (s_hready) begin
        dph_valid_q <= s_htrans[1];
        dph_write_q <= s_hwrite;
        dph_addr_q  <= s_haddr;
      end
      if (buf_we) line_buf_q[data_cnt_q[WselW-1:0]] <= m_hrdata;
      if (state_q == StWrite) begin
        rr_q[idx] <= (rr_q[idx] == RrW'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_icache_assoc.sv
// Directed bench for ahb_icache_assoc: CPU-side master task, downstream memory slave
// with one wait state per beat and optional error injection.
module tb_ahb_icache_assoc;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hburst;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hrdata;
  logic        m_hready;
  logic        m_hresp;
  logic        inv_all;
  logic        stat_hit;
  logic        stat_miss;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_icache_assoc #(
    .CACHE_SIZE (8192),
    .CACHE_LINE (128),
    .WAYS       (2),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) dut (
    .hclk      (hclk),
    .hrstn     (hrstn),
    .s_haddr   (s_haddr),
    .s_htrans  (s_htrans),
    .s_hwrite  (s_hwrite),
    .s_hrdata  (s_hrdata),
    .s_hready  (s_hready),
    .s_hresp   (s_hresp),
    .m_haddr   (m_haddr),
    .m_htrans  (m_htrans),
    .m_hburst  (m_hburst),
    .m_hwrite  (m_hwrite),
    .m_hsize   (m_hsize),
    .m_hrdata  (m_hrdata),
    .m_hready  (m_hready),
    .m_hresp   (m_hresp),
    .inv_all   (inv_all),
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  // Downstream slave: one wait state per beat, error on beat err_beat (-1 = never).
  int          err_beat = -1;
  int          xfer_cnt = 0;
  logic [31:0] xfer_first, xfer_last;
  logic [1:0]  xfer_first_trans;
  logic [2:0]  xfer_burst;
  logic        dp_act = 1'b0;
  logic [31:0] dp_addr;
  int          dp_wait, beat_no;
  logic        err_second = 1'b0;

  always @(negedge hclk) begin
    if (!hrstn) begin
      m_hready   = 1'b1;
      m_hresp    = 1'b0;
      m_hrdata   = '0;
      dp_act     = 1'b0;
      err_second = 1'b0;
    end else begin
      if (err_second) begin
        m_hready   = 1'b1;
        m_hresp    = 1'b1;
        err_second = 1'b0;
        dp_act     = 1'b0;
      end else if (dp_act && dp_wait > 0) begin
        m_hready = 1'b0;
        m_hresp  = 1'b0;
        dp_wait--;
      end else if (dp_act && beat_no == err_beat) begin
        m_hready   = 1'b0;
        m_hresp    = 1'b1;
        err_second = 1'b1;
      end else if (dp_act) begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = mem_word(dp_addr);
        beat_no++;
        dp_act = 1'b0;
      end else begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
      end
      #1;
      if (m_hready && m_htrans[1]) begin
        if (xfer_cnt == 0) begin
          xfer_first       = m_haddr;
          xfer_first_trans = m_htrans;
          xfer_burst       = m_hburst;
        end
        if (m_htrans == 2'b10) beat_no = 0;
        xfer_last = m_haddr;
        xfer_cnt++;
        dp_act  = 1'b1;
        dp_addr = m_haddr;
        dp_wait = 1;
      end
    end
  end

  // Results of the last CPU transfer.
  logic [31:0] x_data;
  int          x_waits;
  logic        x_err, x_err_first, x_hit, x_miss;

  task automatic cpu_xfer(input logic [31:0] addr, input logic wr);
    int guard;
    @(negedge hclk);
    s_haddr  = addr;
    s_htrans = 2'b10;
    s_hwrite = wr;
    #2;
    guard = 0;
    while (!s_hready && guard < 200) begin
      @(negedge hclk);
      #2;
      guard++;
    end
    if (guard >= 200) check_eq("addr_phase_timeout", 32'(s_hready), 32'd1);
    @(negedge hclk);
    s_htrans    = 2'b00;
    s_hwrite    = 1'b0;
    x_waits     = 0;
    x_err_first = 1'b0;
    x_hit       = 1'b0;
    x_miss      = 1'b0;
    #2;
    while (!s_hready && x_waits < 200) begin
      x_err_first |= s_hresp;
      x_hit       |= stat_hit;
      x_miss      |= stat_miss;
      x_waits++;
      @(negedge hclk);
      #2;
    end
    if (x_waits >= 200) check_eq("data_phase_timeout", 32'(s_hready), 32'd1);
    x_hit  |= stat_hit;
    x_miss |= stat_miss;
    x_data  = s_hrdata;
    x_err   = s_hresp;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] addr, input logic exp_hit);
    cpu_xfer(addr, 1'b0);
    check_eq({tag, "_data"}, x_data, mem_word(addr));
    check_eq({tag, "_resp"}, 32'(x_err), 32'd0);
    check_eq({tag, "_hit"}, 32'(x_hit), 32'(exp_hit));
    check_eq({tag, "_miss"}, 32'(x_miss), 32'(!exp_hit));
    if (exp_hit) check_eq({tag, "_waits"}, 32'(x_waits), 32'd0);
    else check_eq({tag, "_waits_ge4"}, 32'(x_waits >= 4), 32'd1);
  endtask

  task automatic wait_xfers(input int n);
    int guard = 0;
    while (xfer_cnt < n && guard < 200) begin
      @(negedge hclk);
      guard++;
    end
    if (guard >= 200) check_eq("wait_xfers_timeout", 32'(xfer_cnt), 32'(n));
  endtask

  initial begin
    hrstn    = 1'b0;
    s_haddr  = '0;
    s_htrans = 2'b00;
    s_hwrite = 1'b0;
    inv_all  = 1'b0;
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    #13;
    check_eq("rst_s_hready", 32'(s_hready), 32'd1);
    check_eq("rst_s_hresp", 32'(s_hresp), 32'd0);
    check_eq("rst_s_hrdata", s_hrdata, 32'd0);
    check_eq("rst_m_htrans", 32'(m_htrans), 32'd0);
    check_eq("rst_m_haddr", m_haddr, 32'd0);
    check_eq("rst_stats", 32'({stat_hit, stat_miss}), 32'd0);
    check_eq("m_hsize", 32'(m_hsize), 32'd2);
    check_eq("m_hwrite", 32'(m_hwrite), 32'd0);
    @(negedge hclk);
    hrstn = 1'b1;
    repeat (2) @(negedge hclk);

    // 1: cold miss refills one INCR4 burst, then the neighbouring word hits.
    xfer_cnt = 0;
    read_expect("cold_100", 32'h100, 1'b0);
    check_eq("burst_count", 32'(xfer_cnt), 32'd4);
    check_eq("burst_first", xfer_first, 32'h100);
    check_eq("burst_last", xfer_last, 32'h10c);
    check_eq("burst_nonseq", 32'(xfer_first_trans), 32'd2);
    check_eq("burst_incr4", 32'(xfer_burst), 32'd3);
    xfer_cnt = 0;
    read_expect("hit_104", 32'h104, 1'b1);
    check_eq("hit_no_traffic", 32'(xfer_cnt), 32'd0);

    // 2: three lines in one set; round robin evicts way 0 (0x0000).
    read_expect("set0_0000", 32'h0000, 1'b0);
    read_expect("set0_1000", 32'h1000, 1'b0);
    read_expect("set0_2000", 32'h2008, 1'b0);
    read_expect("set0_1000_hit", 32'h100c, 1'b1);
    read_expect("set0_0000_evicted", 32'h0004, 1'b0);

    // 3: downstream error on beat 2 gives the two-cycle upstream error; line stays invalid.
    err_beat = 2;
    xfer_cnt = 0;
    cpu_xfer(32'h308, 1'b0);
    err_beat = -1;
    check_eq("derr_first_cycle", 32'(x_err_first), 32'd1);
    check_eq("derr_second_cycle", 32'(x_err), 32'd1);
    check_eq("derr_abandoned", 32'(xfer_cnt), 32'd3);
    check_eq("derr_htrans_idle", 32'(m_htrans), 32'd0);
    read_expect("derr_reread", 32'h308, 1'b0);

    // 4: upstream write is answered with ERROR and no downstream traffic.
    xfer_cnt = 0;
    cpu_xfer(32'h200, 1'b1);
    check_eq("wr_err_first", 32'(x_err_first), 32'd1);
    check_eq("wr_err_second", 32'(x_err), 32'd1);
    check_eq("wr_no_traffic", 32'(xfer_cnt), 32'd0);
    check_eq("wr_no_stats", 32'({x_hit, x_miss}), 32'd0);

    // 5: flush mid-fill still answers correctly, but the line is left invalid.
    xfer_cnt = 0;
    fork
      read_expect("inv_fill_408", 32'h408, 1'b0);
      begin
        wait_xfers(2);
        @(negedge hclk);
        inv_all = 1'b1;
        @(negedge hclk);
        inv_all = 1'b0;
      end
    join
    read_expect("inv_reread_404", 32'h404, 1'b0);
    read_expect("inv_old_100", 32'h100, 1'b0);

    // 6: reset during fill returns the bus outputs at once; everything misses afterwards.
    xfer_cnt = 0;
    fork
      cpu_xfer(32'h500, 1'b0);
      begin
        wait_xfers(2);
        @(negedge hclk);
        #3;
        hrstn = 1'b0;
        #1;
        check_eq("mid_rst_m_htrans", 32'(m_htrans), 32'd0);
        check_eq("mid_rst_s_hready", 32'(s_hready), 32'd1);
        check_eq("mid_rst_m_haddr", m_haddr, 32'd0);
        check_eq("mid_rst_s_hresp", 32'(s_hresp), 32'd0);
        repeat (2) @(negedge hclk);
        hrstn = 1'b1;
      end
    join
    repeat (2) @(negedge hclk);
    read_expect("post_rst_100", 32'h100, 1'b0);
    read_expect("post_rst_1000", 32'h1000, 1'b0);
    read_expect("post_rst_404", 32'h404, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
